// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV64 funct3 encodings for loads and stores (stores use the low four)
//   - FSM state encoding, also exported on the unit's debug port
//   - lane size type plus a helper mapping funct3 to the access width
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } lane_size_t;

  // funct3[1:0] encodes the access width for both loads and stores.
  function automatic lane_size_t size_of(input logic [2:0] funct3);
    return lane_size_t'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit. Purely combinational.
// Ports:
//   offset      in  3   byte offset within the doubleword (addr[2:0])
//   funct3      in  3   RV64 funct3 of the access
//   word        in  64  doubleword read from memory
//   wdata       in  64  store data, low bytes used for sub-doubleword stores
//   load_data   out 64  selected lane, sign- or zero-extended per funct3
//   merged_word out 64  word with the addressed lanes replaced by store data
//   misaligned  out 1   offset is not a multiple of the access size
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged_word,
  output logic        misaligned
);

  logic [5:0]  bit_off;
  logic [63:0] shifted;
  logic [63:0] lane_mask;
  logic [63:0] lane_data;

  assign bit_off = {offset, 3'b000};
  assign shifted = word >> bit_off;

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    load_data = shifted;
      F3_BU:   load_data = {56'd0, shifted[7:0]};
      F3_HU:   load_data = {48'd0, shifted[15:0]};
      F3_WU:   load_data = {32'd0, shifted[31:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    lane_mask  = '1;
    lane_data  = wdata;
    misaligned = 1'b0;
    case (size_of(funct3))
      SZ_BYTE: begin
        lane_mask = 64'h0000_0000_0000_00FF;
        lane_data = {56'd0, wdata[7:0]};
      end
      SZ_HALF: begin
        lane_mask  = 64'h0000_0000_0000_FFFF;
        lane_data  = {48'd0, wdata[15:0]};
        misaligned = offset[0];
      end
      SZ_WORD: begin
        lane_mask  = 64'h0000_0000_FFFF_FFFF;
        lane_data  = {32'd0, wdata[31:0]};
        misaligned = |offset[1:0];
      end
      default: begin
        lane_mask  = '1;
        lane_data  = wdata;
        misaligned = |offset;
      end
    endcase
  end

  assign merged_word = (word & ~(lane_mask << bit_off)) | (lane_data << bit_off);

endmodule

// File: rtl/load_store_unit.sv
// Sequencer between the execute stage and a 64-bit doubleword data memory.
// Handles RV64 loads (LB/LH/LW/LD/LBU/LHU/LWU) and stores (SB/SH/SW/SD);
// sub-doubleword stores are read-modify-write because memory only takes
// whole doublewords.
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_write, req_funct3     1=store/0=load, RV64 funct3
//   req_addr, req_wdata       byte address, store data
//   resp_valid                one-cycle completion pulse (no backpressure)
//   resp_error, resp_rdata    error flag, aligned/extended load data
//   mem_read, mem_write       memory strobes (never both high)
//   mem_address               {word_index, 3'b000}
//   mem_write_data            doubleword to write
//   mem_read_data             combinational read data from memory
//   dbg_state                 current FSM state
//
// Handshake: a request transfers on a posedge where req_valid & req_ready;
// req_ready is high only in IDLE, and the requester holds req_valid and the
// request fields stable until that edge. resp_valid is a single-cycle pulse
// the consumer must take when it appears.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [63:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data,
  output lsu_state_t  dbg_state
);

  lsu_state_t  state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] old_word;

  logic [2:0]  al_offset;
  logic [2:0]  al_funct3;
  logic [63:0] al_word;
  logic [63:0] load_data;
  logic [63:0] merged_word;
  logic        misaligned;

  logic        range_err;
  logic        funct3_err;
  logic        req_err;

  // One aligner serves both phases: in IDLE it looks at the incoming request
  // (only the misalign flag matters there); afterwards at the latched one.
  // During MERGE the word is the captured old doubleword, not the bus.
  assign al_offset = (state == ST_IDLE)  ? req_addr[2:0] : r_addr[2:0];
  assign al_funct3 = (state == ST_IDLE)  ? req_funct3    : r_funct3;
  assign al_word   = (state == ST_MERGE) ? old_word      : mem_read_data;

  lsu_lane_align u_align (
    .offset      (al_offset),
    .funct3      (al_funct3),
    .word        (al_word),
    .wdata       (r_wdata),
    .load_data   (load_data),
    .merged_word (merged_word),
    .misaligned  (misaligned)
  );

  assign range_err  = ({3'b000, req_addr[63:3]} >= 64'(MEM_WORDS));
  assign funct3_err = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
  assign req_err    = range_err | funct3_err | misaligned;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      r_write    <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
      old_word   <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            resp_rdata <= '0;
            resp_error <= req_err;
            state      <= req_err ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_write) begin
            resp_rdata <= load_data;
            state      <= ST_RESP;
          end else if (r_funct3 == F3_D) begin
            state <= ST_RESP;
          end else begin
            old_word <= mem_read_data;
            state    <= ST_MERGE;
          end
        end
        ST_MERGE: state <= ST_RESP;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from the state register, so an
  // asynchronous reset drops them the moment the state returns to IDLE.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state)
      ST_ACCESS: begin
        mem_address = {r_addr[63:3], 3'b000};
        if (r_write && (r_funct3 == F3_D)) begin
          mem_write      = 1'b1;
          mem_write_data = r_wdata;
        end else begin
          mem_read = 1'b1;
        end
      end
      ST_MERGE: begin
        mem_address    = {r_addr[63:3], 3'b000};
        mem_write      = 1'b1;
        mem_write_data = merged_word;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int W = 75;  // {error, write_pulses[1:0], latency[7:0], rdata[63:0]}

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_error;
  logic [63:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;
  lsu_state_t  dbg_state;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_error     (resp_error),
    .resp_rdata     (resp_rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- data memory ----------------
  logic [63:0] mem [64];
  assign mem_read_data = mem_read ? mem[mem_address[8:3]] : 64'd0;
  always @(posedge clock) if (mem_write) mem[mem_address[8:3]] <= mem_write_data;

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [64];

  task automatic model(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] d, output logic e, output logic [63:0] r,
                       output int lat, output int nwr);
    int size;
    int off;
    logic [63:0] widx;
    logic [63:0] mask;
    logic [63:0] word;
    logic [63:0] v;
    size = 1 << f3[1:0];
    off  = int'(a[2:0]);
    widx = a >> 3;
    e = (w ? f3[2] : (f3 == 3'd7)) || ((a % 64'(size)) != 64'd0) || (widx >= 64'd64);
    r = '0; lat = 1; nwr = 0;
    if (!e) begin
      mask = (size == 8) ? ~64'd0 : ((64'd1 << (8 * size)) - 64'd1);
      word = ref_mem[widx[5:0]];
      if (!w) begin
        v = (word >> (8 * off)) & mask;
        if (!f3[2] && size < 8 && v[8 * size - 1]) v = v | ~mask;
        r = v; lat = 2;
      end else begin
        ref_mem[widx[5:0]] = (word & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
        lat = (size == 8) ? 2 : 3;
        nwr = 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           wr_cycles = 0;
  int           last_acc = 0;
  logic         err_pending = 1'b0;
  logic         cur_tracked = 1'b0;
  logic [63:0]  cur_addr = '0;
  logic [63:0]  last_rdata = '0;
  logic         last_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clock) begin
    logic [W-1:0] e;
    int a;
    if (!reset_n) begin
      wr_cycles = 0;
    end else begin
      chk("rw_exclusive", 64'(mem_read & mem_write), 64'd0);
      if (req_ready)
        chk("idle_mem_quiet", 64'(mem_read | mem_write | (|mem_address) | (|mem_write_data)), 64'd0);
      if (err_pending)
        chk("error_no_mem", 64'(mem_read | mem_write), 64'd0);
      if (mem_read || mem_write)
        chk("mem_address", mem_address, {cur_addr[63:3], 3'b000});
      if (mem_write && cur_tracked)
        chk("mem_write_data", mem_write_data, ref_mem[cur_addr[8:3]]);
      if (mem_write) wr_cycles++;
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          fail("spurious_resp_valid");
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("resp_rdata", resp_rdata, e[63:0]);
          chk("resp_error", 64'(resp_error), 64'(e[74]));
          chk("latency", 64'(cyc - a + 1), 64'(e[71:64]));
          chk("write_pulses", 64'(wr_cycles), 64'(e[73:72]));
        end
        last_rdata  = resp_rdata;
        last_err    = resp_error;
        wr_cycles   = 0;
        err_pending = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives a request at the negedge and returns right after the accepting
  // posedge; req_valid stays high so a following call is back-to-back.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] d, input logic track);
    logic        e;
    logic [63:0] r;
    int          lat;
    int          nwr;
    int          guard;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    cur_addr    = a;
    cur_tracked = track;
    last_acc    = cyc + 1;
    if (track) begin
      model(w, f3, a, d, e, r, lat, nwr);
      exp_q.push_back({e, nwr[1:0], lat[7:0], r});
      acc_q.push_back(cyc + 1);
      err_pending = e;
    end else begin
      err_pending = 1'b0;
    end
    @(posedge clock);
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic drain();
    idle(6);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1;
    int a2;
    logic        w;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] word;
    int          sz;

    for (int i = 0; i < 64; i++) begin
      mem[i] = {$urandom(), $urandom()};
      ref_mem[i] = mem[i];
    end
    mem[1] = 64'h0123_4567_89AB_CDEF; ref_mem[1] = mem[1];
    mem[2] = 64'h8877_6655_4433_2211; ref_mem[2] = mem[2];

    // reset state
    repeat (3) @(negedge clock);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_mem_strobes", 64'(mem_read | mem_write), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("post_reset_req_ready", 64'(req_ready), 64'd1);
    chk("post_reset_resp_rdata", resp_rdata, 64'd0);
    chk("post_reset_resp_error", 64'(resp_error), 64'd0);

    // test 1: loads with extension
    do_req(1'b0, F3_B, 64'h13, 64'd0, 1'b1); drain();
    chk("lb_0x13", last_rdata, 64'h0000_0000_0000_0044);
    do_req(1'b0, F3_B, 64'h17, 64'd0, 1'b1); drain();
    chk("lb_0x17", last_rdata, 64'hFFFF_FFFF_FFFF_FF88);
    do_req(1'b0, F3_HU, 64'h16, 64'd0, 1'b1); drain();
    chk("lhu_0x16", last_rdata, 64'h0000_0000_0000_8877);

    // test 2: byte store via read-modify-write
    do_req(1'b1, F3_B, 64'h11, 64'hAB, 1'b1); drain();
    chk("sb_word2", mem[2], 64'h8877_6655_4433_AB11);

    // test 3: doubleword store and reads back
    do_req(1'b1, F3_D, 64'h18, 64'hDEAD_BEEF_0000_0001, 1'b1); drain();
    do_req(1'b0, F3_D, 64'h18, 64'd0, 1'b1); drain();
    chk("ld_0x18", last_rdata, 64'hDEAD_BEEF_0000_0001);
    do_req(1'b0, F3_W, 64'h1C, 64'd0, 1'b1); drain();
    chk("lw_0x1c", last_rdata, 64'hFFFF_FFFF_DEAD_BEEF);
    do_req(1'b0, F3_WU, 64'h1C, 64'd0, 1'b1); drain();
    chk("lwu_0x1c", last_rdata, 64'h0000_0000_DEAD_BEEF);

    // test 4: error requests
    do_req(1'b1, F3_W, 64'h2, 64'h1234, 1'b1); drain();
    chk("sw_misaligned_err", 64'(last_err), 64'd1);
    chk("sw_misaligned_rdata", last_rdata, 64'd0);
    do_req(1'b0, F3_D, 64'h200, 64'd0, 1'b1); drain();
    chk("ld_range_err", 64'(last_err), 64'd1);
    do_req(1'b0, 3'b111, 64'h0, 64'd0, 1'b1); drain();
    chk("ld_f3_111_err", 64'(last_err), 64'd1);
    chk("ld_f3_111_rdata", last_rdata, 64'd0);

    // test 5: reset during the MERGE cycle of SH 0x8
    do_req(1'b1, F3_H, 64'h8, 64'hBEEF, 1'b0);
    @(negedge clock);
    req_valid = 1'b0;
    chk("pre_merge_state", 64'(dbg_state), 64'(ST_ACCESS));
    @(negedge clock);
    chk("merge_state", 64'(dbg_state), 64'(ST_MERGE));
    chk("merge_mem_write", 64'(mem_write), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mem_write_async", 64'(mem_write), 64'd0);
    chk("abort_req_ready_async", 64'(req_ready), 64'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    repeat (3) @(negedge clock);
    chk("abort_no_resp", 64'(resp_valid), 64'd0);
    chk("abort_word1", mem[1], 64'h0123_4567_89AB_CDEF);

    // test 6: back-to-back SB then LB with req_valid held
    do_req(1'b1, F3_B, 64'h21, 64'h5A, 1'b1);
    a1 = last_acc;
    do_req(1'b0, F3_B, 64'h21, 64'd0, 1'b1);
    a2 = last_acc;
    drain();
    chk("b2b_lb_data", last_rdata, 64'h0000_0000_0000_005A);
    chk("b2b_accept_gap", 64'(a2 - a1), 64'd4);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (w && f3[2] && $urandom_range(0, 5) != 0) f3[2] = 1'b0;
      sz = 1 << f3[1:0];
      word = ($urandom_range(0, 9) < 8) ? 64'($urandom_range(0, 7)) : 64'($urandom_range(60, 70));
      if ($urandom_range(0, 49) == 0) word[60] = 1'b1;
      addr = (word << 3) | ($urandom_range(0, 3) == 0 ? 64'($urandom_range(0, 7))
                                                     : 64'($urandom_range(0, 7) & ~(sz - 1)));
      do_req(w, f3, addr, {$urandom(), $urandom()}, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end
    drain();

    for (int i = 0; i < 64; i++) chk("final_memory", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
